ascii_to_bcd_collector: RTL and testbench
=========================================

Name: ascii_to_bcd_collector

Overview:
- Upstream feeder for the BCD-to-binary converter.
- Consumes a byte stream of ASCII characters over a valid/ready handshake.
- Packs decimal digits of one line into a right-justified packed-BCD word: ones digit in bits [3:0].
- On a line terminator, presents the word with a digit count on a valid/ready output; malformed lines are dropped and flagged.

Parameters:
- BCD_DIGIT, 8, number of BCD digits in the output word (legal 1..8); bcd_out width is BCD_DIGIT*4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- ascii_in  input  8  ASCII character
- ascii_valid  input  1  ascii_in valid
- ascii_ready  output  1  block accepts ascii_in this cycle
- bcd_out  output  BCD_DIGIT*4  packed BCD, ones digit in [3:0], unused upper digits 0
- digit_count  output  $clog2(BCD_DIGIT+1)  number of digits received on the line (1..BCD_DIGIT)
- bcd_valid  output  1  bcd_out/digit_count valid
- bcd_ready  input  1  consumer accepts bcd_out
- err_invalid  output  1  one-cycle pulse: non-digit, non-terminator character seen
- err_overflow  output  1  one-cycle pulse: more than BCD_DIGIT digits on a line

Behaviour:
- Reset: async assert while rst_n=0.
  - Outputs: ascii_ready=0 during reset, 1 from first clk after release; bcd_out=0, digit_count=0, bcd_valid=0, err_invalid=0, err_overflow=0.
  - State goes to IDLE.
- Accept event: ascii_valid && ascii_ready on a rising edge.
- Character classes:
  - digit: 0x30..0x39, value = ascii_in[3:0].
  - terminator: 0x0D (CR) or 0x0A (LF).
  - everything else is invalid.
- State IDLE (ascii_ready=1, no digits held):
  - digit → shift register loaded with the digit, count=1, go COLLECT.
  - terminator → ignored (empty line, no output), stay IDLE.
  - invalid → err_invalid pulses next cycle, go DISCARD.
- State COLLECT (ascii_ready=1):
  - digit with count<BCD_DIGIT → shift_reg <= {shift_reg[BCD_DIGIT*4-5:0], digit}, count+1.
  - digit with count==BCD_DIGIT → err_overflow pulses next cycle, go DISCARD; held word is dropped.
  - terminator → bcd_out<=shift_reg, digit_count<=count, bcd_valid=1 next cycle, go OUTPUT.
  - invalid → err_invalid pulses next cycle, go DISCARD.
- State OUTPUT (ascii_ready=0):
  - bcd_out, digit_count and bcd_valid are held stable until bcd_ready=1.
  - On bcd_valid && bcd_ready: bcd_valid=0 next cycle, shift register and count cleared, go IDLE.
  - ascii_ready=1 again in the cycle after the handshake.
  - Latency: terminator accepted at edge N → bcd_valid=1 after edge N; minimum 2 cycles per emitted word including the handshake.
- State DISCARD (ascii_ready=1):
  - Digits and invalid characters are consumed silently; no further error pulses for the same line.
  - Terminator → clear shift register and count, go IDLE; no output.
- Leading zeros count as digits: "007" gives count=3, bcd_out=0x007.
- bcd_out keeps its last emitted value while bcd_valid=0; consumers sample only on handshake.
- Error pulses are exactly one cycle wide and never coincide with bcd_valid rising.
- Reset mid-line or mid-OUTPUT: everything aborts immediately; the pending word is lost and no spurious bcd_valid follows release.
- BCD_DIGIT=1: one digit accepted; a second digit triggers overflow.

Test Plan (BCD_DIGIT=8):
- "1234",CR with bcd_ready=1 → bcd_out=0x00001234, digit_count=4, bcd_valid high exactly 1 cycle; ascii_ready low only during that cycle.
- "98765432",LF with bcd_ready=0 for 5 cycles, then 1 → bcd_out=0x98765432, count=8 held stable 6 cycles; ascii_ready=0 throughout, no input consumed.
- "123456789",LF then "7",CR → err_overflow single pulse after the 9th digit, no output for line 1; line 2 gives bcd_out=0x00000007, count=1.
- "12a4",CR then "5",LF → err_invalid one pulse after 'a', no output for line 1, no second error; line 2 gives 0x00000005.
- CR,LF,CR (empty lines) → no bcd_valid, no errors; then "0",CR → bcd_out=0, count=1, bcd_valid=1.
- "456" then rst_n low 2 cycles mid-line, then "9",CR → no output for "456"; bcd_out=0x00000009, count=1. Repeat with reset asserted while bcd_valid=1 → bcd_valid=0 immediately and stays 0.

Source files
------------

// File: rtl/ascii_to_bcd_collector.sv
// Collects ASCII decimal digits of one line into a right-justified packed-BCD word
// and hands it out over valid/ready when a CR or LF ends the line.
module ascii_to_bcd_collector #(
  parameter int BCD_DIGIT = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         ascii_in,
  input  logic                               ascii_valid,
  output logic                               ascii_ready,
  output logic [BCD_DIGIT*4-1:0]             bcd_out,
  output logic [$clog2(BCD_DIGIT+1)-1:0]     digit_count,
  output logic                               bcd_valid,
  input  logic                               bcd_ready,
  output logic                               err_invalid,
  output logic                               err_overflow
);

  localparam int W  = BCD_DIGIT * 4;
  localparam int CW = $clog2(BCD_DIGIT + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(BCD_DIGIT);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, DISCARD} state_t;

  state_t          state, state_next;
  logic [W-1:0]    shift_reg, shift_next;
  logic [CW-1:0]   count, count_next;
  logic [W-1:0]    bcd_out_next;
  logic [CW-1:0]   digit_count_next;
  logic            bcd_valid_next;
  logic            ascii_ready_next;
  logic            err_invalid_next;
  logic            err_overflow_next;
  logic            accept;
  logic            is_digit;
  logic            is_term;
  logic [W+3:0]    shift_append;

  assign accept       = ascii_valid && ascii_ready;
  assign is_digit     = (ascii_in >= 8'h30) && (ascii_in <= 8'h39);
  assign is_term      = (ascii_in == 8'h0D) || (ascii_in == 8'h0A);
  // Appending the new digit and keeping the low W bits also works for a single-digit word
  assign shift_append = {shift_reg, ascii_in[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      count        <= '0;
      bcd_out      <= '0;
      digit_count  <= '0;
      bcd_valid    <= 1'b0;
      ascii_ready  <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      shift_reg    <= shift_next;
      count        <= count_next;
      bcd_out      <= bcd_out_next;
      digit_count  <= digit_count_next;
      bcd_valid    <= bcd_valid_next;
      ascii_ready  <= ascii_ready_next;
      err_invalid  <= err_invalid_next;
      err_overflow <= err_overflow_next;
    end
  end

  always_comb begin
    state_next        = state;
    shift_next        = shift_reg;
    count_next        = count;
    bcd_out_next      = bcd_out;
    digit_count_next  = digit_count;
    bcd_valid_next    = bcd_valid;
    err_invalid_next  = 1'b0;
    err_overflow_next = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            shift_next = W'(ascii_in[3:0]);
            count_next = CW'(1);
            state_next = COLLECT;
          end else if (!is_term) begin
            err_invalid_next = 1'b1;
            state_next       = DISCARD;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            if (count == MAX_COUNT) begin
              err_overflow_next = 1'b1;
              state_next        = DISCARD;
            end else begin
              shift_next = shift_append[W-1:0];
              count_next = count + CW'(1);
            end
          end else if (is_term) begin
            bcd_out_next     = shift_reg;
            digit_count_next = count;
            bcd_valid_next   = 1'b1;
            state_next       = OUTPUT;
          end else begin
            err_invalid_next = 1'b1;
            state_next       = DISCARD;
          end
        end
      end
      OUTPUT: begin
        if (bcd_valid && bcd_ready) begin
          bcd_valid_next = 1'b0;
          shift_next     = '0;
          count_next     = '0;
          state_next     = IDLE;
        end
      end
      DISCARD: begin
        // The rest of a bad line is swallowed; only its terminator matters
        if (accept && is_term) begin
          shift_next = '0;
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    ascii_ready_next = (state_next != OUTPUT);
  end

endmodule

// File: tb/tb_ascii_to_bcd_collector.sv
// Directed testbench for ascii_to_bcd_collector with BCD_DIGIT=8.
module tb_ascii_to_bcd_collector;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ascii_in;
  logic        ascii_valid;
  logic        ascii_ready;
  logic [31:0] bcd_out;
  logic [3:0]  digit_count;
  logic        bcd_valid;
  logic        bcd_ready;
  logic        err_invalid;
  logic        err_overflow;

  int checks;
  int errors;
  int valid_cycles;
  int inv_pulses;
  int ovf_pulses;
  int hs_count;

  ascii_to_bcd_collector #(.BCD_DIGIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ascii_in     (ascii_in),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ascii_ready),
    .bcd_out      (bcd_out),
    .digit_count  (digit_count),
    .bcd_valid    (bcd_valid),
    .bcd_ready    (bcd_ready),
    .err_invalid  (err_invalid),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, where every DUT output is stable
  always @(negedge clk) begin
    if (bcd_valid) valid_cycles++;
    if (err_invalid) inv_pulses++;
    if (err_overflow) ovf_pulses++;
    if (bcd_valid && bcd_ready) hs_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input byte c);
    for (int k = 0; k < 20 && !ascii_ready; k++) step();
    checks++;
    if (!ascii_ready) begin
      errors++;
      $display("[TB] FAIL send_wait_ready: got ascii_ready=%b required 1 within 20 cycles", ascii_ready);
    end
    ascii_in    = c;
    ascii_valid = 1'b1;
    step();
    ascii_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ascii_ready !== 1'b0 || bcd_valid !== 1'b0 || bcd_out !== 32'h0 || digit_count !== 4'd0 ||
        err_invalid !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b out=%h cnt=%0d ei=%b eo=%b required all 0",
               ascii_ready, bcd_valid, bcd_out, digit_count, err_invalid, err_overflow);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_clk: got %b required 0", ascii_ready);
    end
    step();
    checks++;
    if (ascii_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_release: got %b required 1", ascii_ready);
    end
  endtask

  task automatic test_basic();
    int v0, h0;
    bcd_ready = 1'b1;
    v0 = valid_cycles;
    h0 = hs_count;
    send_str("1234");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || ascii_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_valid: got vld=%b rdy=%b required vld=1 rdy=0", bcd_valid, ascii_ready);
    end
    checks++;
    if (bcd_out !== 32'h00001234 || digit_count !== 4'd4) begin
      errors++;
      $display("[TB] FAIL basic_word: got %h/%0d required 00001234/4", bcd_out, digit_count);
    end
    step();
    checks++;
    if (bcd_valid !== 1'b0 || ascii_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_release: got vld=%b rdy=%b required vld=0 rdy=1", bcd_valid, ascii_ready);
    end
    step();
    checks++;
    if (valid_cycles - v0 !== 1 || hs_count - h0 !== 1) begin
      errors++;
      $display("[TB] FAIL basic_one_cycle: got valid_cycles=%0d handshakes=%0d required 1/1",
               valid_cycles - v0, hs_count - h0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bcd_ready = 1'b0;
    send_str("98765432");
    send_char(8'h0A);
    ascii_in    = "5";
    ascii_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        bcd_ready   = 1'b1;
        ascii_valid = 1'b0;
      end
      if (bcd_valid !== 1'b1 || ascii_ready !== 1'b0 || bcd_out !== 32'h98765432 || digit_count !== 4'd8)
        bad++;
      if (i < 5) step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles required 0 (last out=%h cnt=%0d)",
               bad, bcd_out, digit_count);
    end
    step();
    checks++;
    if (bcd_valid !== 1'b0 || ascii_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: got vld=%b rdy=%b required vld=0 rdy=1", bcd_valid, ascii_ready);
    end
    send_str("3");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000003 || digit_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL hold_no_consume: got vld=%b %h/%0d required 1 00000003/1",
               bcd_valid, bcd_out, digit_count);
    end
    step();
  endtask

  task automatic test_overflow();
    int o0, h0;
    o0 = ovf_pulses;
    h0 = hs_count;
    send_str("123456789");
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_pulse: got %b required 1", err_overflow);
    end
    send_char(8'h0A);
    checks++;
    if (bcd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_no_output: got vld=%b required 0", bcd_valid);
    end
    send_str("7");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000007 || digit_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL ovf_next_line: got vld=%b %h/%0d required 1 00000007/1",
               bcd_valid, bcd_out, digit_count);
    end
    step();
    checks++;
    if (ovf_pulses - o0 !== 1 || hs_count - h0 !== 1) begin
      errors++;
      $display("[TB] FAIL ovf_counts: got pulses=%0d handshakes=%0d required 1/1",
               ovf_pulses - o0, hs_count - h0);
    end
  endtask

  task automatic test_invalid();
    int i0, h0;
    i0 = inv_pulses;
    h0 = hs_count;
    send_str("12a");
    checks++;
    if (err_invalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inv_pulse: got %b required 1", err_invalid);
    end
    send_str("4");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inv_no_output: got vld=%b required 0", bcd_valid);
    end
    send_str("5");
    send_char(8'h0A);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000005 || digit_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL inv_next_line: got vld=%b %h/%0d required 1 00000005/1",
               bcd_valid, bcd_out, digit_count);
    end
    step();
    checks++;
    if (inv_pulses - i0 !== 1 || hs_count - h0 !== 1) begin
      errors++;
      $display("[TB] FAIL inv_counts: got pulses=%0d handshakes=%0d required 1/1",
               inv_pulses - i0, hs_count - h0);
    end
  endtask

  task automatic test_empty_lines();
    int v0, e0;
    v0 = valid_cycles;
    e0 = inv_pulses + ovf_pulses;
    send_char(8'h0D);
    send_char(8'h0A);
    send_char(8'h0D);
    step();
    checks++;
    if (valid_cycles - v0 !== 0 || inv_pulses + ovf_pulses - e0 !== 0) begin
      errors++;
      $display("[TB] FAIL empty_quiet: got valid_cycles=%0d errors=%0d required 0/0",
               valid_cycles - v0, inv_pulses + ovf_pulses - e0);
    end
    send_str("0");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000000 || digit_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL zero_word: got vld=%b %h/%0d required 1 00000000/1",
               bcd_valid, bcd_out, digit_count);
    end
    step();
  endtask

  task automatic test_leading_zeros();
    send_str("007");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000007 || digit_count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL leading_zeros: got vld=%b %h/%0d required 1 00000007/3",
               bcd_valid, bcd_out, digit_count);
    end
    step();
  endtask

  task automatic test_reset_midline();
    int h0;
    h0 = hs_count;
    send_str("456");
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (ascii_ready !== 1'b0 || bcd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midline_reset: got rdy=%b vld=%b required 0/0", ascii_ready, bcd_valid);
    end
    rst_n = 1'b1;
    step();
    send_str("9");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 32'h00000009 || digit_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL midline_next: got vld=%b %h/%0d required 1 00000009/1",
               bcd_valid, bcd_out, digit_count);
    end
    step();
    checks++;
    if (hs_count - h0 !== 1) begin
      errors++;
      $display("[TB] FAIL midline_handshakes: got %0d required 1", hs_count - h0);
    end
  endtask

  task automatic test_reset_output();
    int bad;
    bcd_ready = 1'b0;
    send_str("12");
    send_char(8'h0D);
    checks++;
    if (bcd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL out_reset_pre: got vld=%b required 1", bcd_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_valid !== 1'b0 || bcd_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL out_reset_immediate: got vld=%b out=%h required 0/0", bcd_valid, bcd_out);
    end
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bcd_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL out_reset_stays_low: got %0d valid cycles required 0", bad);
    end
    bcd_ready = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    valid_cycles = 0;
    inv_pulses   = 0;
    ovf_pulses   = 0;
    hs_count     = 0;
    rst_n        = 1'b0;
    ascii_in     = 8'h00;
    ascii_valid  = 1'b0;
    bcd_ready    = 1'b1;

    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_invalid();
    test_empty_lines();
    test_leading_zeros();
    test_reset_midline();
    test_reset_output();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
